// File: rtl/dp_ram_be_if.sv
// Port bundle for dp_ram_be: write port, read port and bulk-clear control.
// master drives requests, slave is the RAM.
interface dp_ram_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    localparam int NBYTES = DATA_W / 8;

    logic              clr;
    logic              busy;
    logic              w_en;
    logic [NBYTES-1:0] w_be;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] data_in;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] data_out;
    logic              r_valid;

    modport master (
        output clr, w_en, w_be, w_addr, data_in, r_en, r_addr,
        input  busy, data_out, r_valid
    );

    modport slave (
        input  clr, w_en, w_be, w_addr, data_in, r_en, r_addr,
        output busy, data_out, r_valid
    );
endinterface

// File: rtl/dp_ram_be.sv
// Dual-port RAM with byte enables, read latency USE_RAM+OUT_REG and a bulk-clear engine.
// Optional write-first forwarding when DP_RAM_BE_BYPASS_EN is defined; read-first otherwise.
module dp_ram_be #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter int USE_RAM = 1,
    parameter int OUT_REG = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    dp_ram_be_if.slave  bus
);
    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              wr_acc;
    logic              vld_p0, vld_p1, vld_p2;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] rd_p0, rd_p1, rd_p2;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NBYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        for (int i = 0; i < NBYTES; i++)
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port traffic is only honoured when the clear engine is idle and not being started.
    assign bus.busy = (state_q == CLEAR);
    assign accept   = (state_q == IDLE) && !bus.clr;
    assign wr_acc   = accept && bus.w_en;
    assign vld_p0   = accept && bus.r_en;
    assign old_word = mem[bus.r_addr];

`ifdef DP_RAM_BE_BYPASS_EN
    assign rd_p0 = (wr_acc && (bus.w_addr == bus.r_addr))
                 ? merge_bytes(old_word, bus.data_in, bus.w_be) : old_word;
`else
    assign rd_p0 = old_word;
`endif

    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q[ADDR_W-1:0]] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NBYTES; i++)
                if (bus.w_be[i]) mem[bus.w_addr][8*i +: 8] <= bus.data_in[8*i +: 8];
        end
    end

    // ---- stage p0 -> p1: synchronous RAM read register ----
    if (USE_RAM != 0) begin : g_p1
        logic [DATA_W-1:0] rd_p1_q;
        logic              vld_p1_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_p1_q  <= '0;
                vld_p1_q <= 1'b0;
            end else begin
                vld_p1_q <= vld_p0;
                if (vld_p0) rd_p1_q <= rd_p0;
            end
        end
        assign rd_p1  = rd_p1_q;
        assign vld_p1 = vld_p1_q;
    end else begin : g_p1_comb
        assign rd_p1  = rd_p0;
        assign vld_p1 = vld_p0;
    end

    // ---- stage p1 -> p2: optional output register ----
    if (OUT_REG != 0) begin : g_p2
        logic [DATA_W-1:0] rd_p2_q;
        logic              vld_p2_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_p2_q  <= '0;
                vld_p2_q <= 1'b0;
            end else begin
                vld_p2_q <= vld_p1;
                if (vld_p1) rd_p2_q <= rd_p1;
            end
        end
        assign rd_p2  = rd_p2_q;
        assign vld_p2 = vld_p2_q;
    end else begin : g_p2_comb
        assign rd_p2  = rd_p1;
        assign vld_p2 = vld_p1;
    end

    assign bus.data_out = rd_p2;
    assign bus.r_valid  = vld_p2;
endmodule

// File: tb/tb_dp_ram_be.sv
// Directed bench for dp_ram_be: three instances with latency 0, 1 and 2 share one stimulus.
module tb_dp_ram_be;
    localparam int DW = 32;
    localparam int AW = 6;
`ifdef DP_RAM_BE_BYPASS_EN
    localparam logic [31:0] RDW_EXP = 32'hA0B00304;
`else
    localparam logic [31:0] RDW_EXP = 32'h01020304;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr, w_en, r_en;
    logic [3:0]    w_be;
    logic [AW-1:0] w_addr, r_addr;
    logic [31:0]   data_in;

    logic [31:0]   dout [3];
    logic [2:0]    vld, bsy;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_cnt, bad, cyc, errs;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dp_ram_be_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        assign bus.clr     = clr;
        assign bus.w_en    = w_en;
        assign bus.w_be    = w_be;
        assign bus.w_addr  = w_addr;
        assign bus.data_in = data_in;
        assign bus.r_en    = r_en;
        assign bus.r_addr  = r_addr;
        dp_ram_be #(
            .DATA_W (DW),
            .ADDR_W (AW),
            .USE_RAM((g == 0) ? 0 : 1),
            .OUT_REG((g == 2) ? 1 : 0)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
        assign dout[g] = bus.data_out;
        assign vld[g]  = bus.r_valid;
        assign bsy[g]  = bus.busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [31:0] d, input logic [3:0] be);
        w_en = 1'b1; w_be = be; w_addr = addr[AW-1:0]; data_in = d;
        step();
        w_en = 1'b0;
    endtask

    task automatic rd(input int addr);
        r_en = 1'b1; r_addr = addr[AW-1:0];
        step();
        r_en = 1'b0;
    endtask

    initial begin
        clr = 0; w_en = 0; r_en = 0; w_be = 0; w_addr = 0; r_addr = 0; data_in = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step(); step();
        check("rst_dout_l1", dout[1], 32'h0);
        check("rst_vld_l1",  vld[1], 1'b0);
        check("rst_busy",    bsy[1], 1'b0);
        check("rst_dout_l2", dout[2], 32'h0);
        rst_n = 1'b1;
        step();

        // byte-enable merge
        wr(5, 32'hAABBCCDD, 4'hF);
        wr(5, 32'h11223344, 4'b0101);
        r_en = 1'b1; r_addr = 5; #1;
        check("byte_l0_dout", dout[0], 32'hAA22CC44);
        check("byte_l0_vld",  vld[0], 1'b1);
        step();
        r_en = 1'b0;
        check("byte_l1_dout", dout[1], 32'hAA22CC44);
        check("byte_l1_vld",  vld[1], 1'b1);
        step();
        check("byte_l1_vld_once", vld[1], 1'b0);
        check("byte_l2_dout", dout[2], 32'hAA22CC44);
        check("byte_l2_vld",  vld[2], 1'b1);
        step();
        check("byte_l2_vld_once", vld[2], 1'b0);
        wr(5, 32'h0, 4'h0);
        rd(5);
        check("be0_noop", dout[1], 32'hAA22CC44);

        // latency sweep, back-to-back reads of addr 0..3
        for (int i = 0; i < 4; i++) wr(i, 32'h100 + i, 4'hF);
        for (int k = 0; k < 6; k++) begin
            r_en = (k < 4); r_addr = k[AW-1:0]; #1;
            check("sweep_l0_vld", vld[0], k < 4);
            if (k < 4) check("sweep_l0_dout", dout[0], 32'h100 + k);
            step();
            check("sweep_l1_vld", vld[1], k < 4);
            if (k < 4) check("sweep_l1_dout", dout[1], 32'h100 + k);
            check("sweep_l2_vld", vld[2], (k >= 1) && (k < 5));
            if ((k >= 1) && (k < 5)) check("sweep_l2_dout", dout[2], 32'h100 + k - 1);
        end
        r_en = 1'b0;

        // idle hold
        wr(9, 32'h12345678, 4'hF);
        rd(9);
        check("hold_first_vld", vld[1], 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_dout", dout[1], 32'h12345678);
            check("hold_vld",  vld[1], 1'b0);
        end

        // same-address read during write
        wr(3, 32'h01020304, 4'hF);
        w_en = 1'b1; w_be = 4'b1100; w_addr = 3; data_in = 32'hA0B0C0D0;
        r_en = 1'b1; r_addr = 3; #1;
        check("rdw_l0", dout[0], RDW_EXP);
        step();
        w_en = 1'b0; r_en = 1'b0;
        check("rdw_l1", dout[1], RDW_EXP);
        rd(3);
        check("rdw_after", dout[1], 32'hA0B00304);

        // bulk clear
        for (int a = 0; a < 64; a++) wr(a, 32'hFFFFFFFF, 4'hF);
        clr = 1'b1; w_en = 1'b1; w_be = 4'hF; w_addr = 7; data_in = 32'h12345678;
        r_en = 1'b1; r_addr = 7;
        step();
        clr = 1'b0; w_addr = 0; data_in = 32'hDEADBEEF; r_addr = 0;
        check("clr_busy_start", bsy[1], 1'b1);
        check("clr_req_no_vld", vld[1], 1'b0);
        busy_cnt = 1; bad = 0; cyc = 0;
        while (bsy[1] && cyc < 200) begin
            if (vld[0] || vld[1]) bad++;
            clr = (cyc == 30);
            step();
            cyc++;
            if (bsy[1]) busy_cnt++;
        end
        check("clr_last_vld", vld[1], 1'b0);
        clr = 1'b0; w_en = 1'b0; r_en = 1'b0;
        check("clr_busy_cycles", busy_cnt, 64);
        check("clr_busy_drop", bsy[1], 1'b0);
        check("clr_no_vld_busy", bad, 0);
        errs = 0;
        for (int a = 0; a < 64; a++) begin
            rd(a);
            if (dout[1] !== 32'h0 || vld[1] !== 1'b1) errs++;
        end
        check("clr_all_zero", errs, 0);

        // reset in the middle of a clear
        for (int a = 0; a < 20; a++) wr(a, 32'h5A5A5A5A, 4'hF);
        wr(20, 32'hCAFEF00D, 4'hF);
        rd(20);
        step();
        check("midclr_pre_dout", dout[2], 32'hCAFEF00D);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) step();
        check("midclr_busy_before", bsy[1], 1'b1);
        rst_n = 1'b0; #1;
        check("midclr_busy",    bsy[1], 1'b0);
        check("midclr_dout_l1", dout[1], 32'h0);
        check("midclr_vld_l1",  vld[1], 1'b0);
        check("midclr_dout_l2", dout[2], 32'h0);
        step();
        rst_n = 1'b1;
        step();
        errs = 0;
        for (int a = 0; a < 10; a++) begin
            rd(a);
            if (dout[1] !== 32'h0) errs++;
        end
        check("midclr_cleared", errs, 0);
        rd(10);
        check("midclr_addr10", dout[1], 32'h5A5A5A5A);
        rd(20);
        check("midclr_addr20", dout[1], 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
